// File: rtl/add_seq_if.sv
// add_seq_if: handshake bundle between the add sequencer, its operand sources,
// the add datapath and the compress stage.
interface add_seq_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic             abort;
    logic             busy;
    logic [4:0]       ops_valid;
    logic             ops_hold;
    logic             add_rst;
    logic             add_enable;
    logic             add_valid;
    logic [2:0]       add_state;
    logic             out_valid;
    logic             out_ready;
    logic             err_timeout;
    logic             err_state;
    logic [CNT_W-1:0] run_cycles;

    modport master (
        input  start, abort, ops_valid, add_valid, add_state, out_ready,
        output busy, ops_hold, add_rst, add_enable, out_valid, err_timeout, err_state, run_cycles
    );

    modport slave (
        output start, abort, ops_valid, add_valid, add_state, out_ready,
        input  busy, ops_hold, add_rst, add_enable, out_valid, err_timeout, err_state, run_cycles
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: sequencer for the u/v add datapath with RUN watchdog and abort path.
// Optional ADD_SEQ_CTRL_STATE_CHECK_EN: validate datapath add_state when add_valid is seen.
module add_seq_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input logic       clk,
    input logic       rst_n,
    add_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, WAIT_OPS, CLEAR, RUN, DONE, ERR, ABORT} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, run_d;
    logic             tmo_d, st_d;
    logic             bad_valid, lost_valid;

`ifdef ADD_SEQ_CTRL_STATE_CHECK_EN
    assign bad_valid  = bus.add_state != 3'b111;
    assign lost_valid = !bus.add_valid;
`else
    assign bad_valid  = 1'b0;
    assign lost_valid = 1'b0;
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        run_d   = bus.run_cycles;
        tmo_d   = bus.err_timeout;
        st_d    = bus.err_state;
        case (state)
            IDLE:     state_d = bus.start ? WAIT_OPS : IDLE;
            WAIT_OPS: state_d = &bus.ops_valid ? CLEAR : WAIT_OPS;
            CLEAR: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt + 1'b1;
                if (bus.add_valid && bad_valid) begin
                    state_d = ERR;
                    st_d    = 1'b1;
                end else if (bus.add_valid) begin
                    state_d = DONE;
                    run_d   = cnt + 1'b1;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERR;
                    tmo_d   = 1'b1;
                end
            end
            DONE: begin
                if (lost_valid) begin
                    state_d = ERR;
                    st_d    = 1'b1;
                end else if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            ERR:     state_d = bus.abort ? ABORT : ERR;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort overrides every transition, and a result seen in the same cycle is discarded
        if (bus.abort && state inside {WAIT_OPS, CLEAR, RUN, DONE}) begin
            state_d = ABORT;
            run_d   = bus.run_cycles;
        end
        if (state_d == ABORT) begin
            tmo_d = 1'b0;
            st_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.ops_hold    <= 1'b0;
            bus.add_rst     <= 1'b0;
            bus.add_enable  <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.err_timeout <= 1'b0;
            bus.err_state   <= 1'b0;
            bus.run_cycles  <= '0;
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            bus.busy        <= state_d != IDLE;
            bus.ops_hold    <= state_d inside {CLEAR, RUN};
            bus.add_rst     <= state_d inside {CLEAR, ERR, ABORT};
            bus.add_enable  <= state_d == RUN;
            bus.out_valid   <= state_d == DONE;
            bus.err_timeout <= tmo_d;
            bus.err_state   <= st_d;
            bus.run_cycles  <= run_d;
        end
    end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: randomized scoreboard bench for add_seq_ctrl with a latency-driven datapath model.
module tb_add_seq_ctrl;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(TIMEOUT + 1);

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   dp_cnt;
    int   dp_lat = 1000;
    bit   dp_bad = 1'b0;
    int   en_cnt = 0;
    bit   err_prev = 1'b0;
    exp_t exp_q[$];

    add_seq_if #(.CNT_W(CW)) bus ();

    add_seq_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // datapath stand-in: result becomes valid once it has seen dp_lat enabled cycles
    always @(posedge clk or negedge rst_n)
        if (!rst_n) dp_cnt <= 0;
        else if (bus.add_rst) dp_cnt <= 0;
        else if (bus.add_enable) dp_cnt <= dp_cnt + 1;

    assign bus.add_valid = dp_cnt >= dp_lat;
    assign bus.add_state = bus.add_valid ? (dp_bad ? 3'b101 : 3'b111) : 3'(dp_cnt);

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    // reference: a pass of lat datapath cycles finishes in lat+1 RUN cycles unless the watchdog fires first
    function automatic exp_t model(int lat, bit bad);
        exp_t e;
        if (lat + 1 > TIMEOUT) begin
            e.kind = 1;
            e.cyc  = TIMEOUT;
        end else begin
`ifdef ADD_SEQ_CTRL_STATE_CHECK_EN
            e.kind = bad ? 2 : 0;
`else
            e.kind = 0;
`endif
            e.cyc = lat + 1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        bit   err_now;
        err_now = bus.err_timeout || bus.err_state;
        if (!rst_n) begin
            en_cnt   = 0;
            err_prev = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("result_kind", 0, e.kind);
                    check("run_cycles", int'(bus.run_cycles), e.cyc);
                    check("enable_cycles", en_cnt, e.cyc);
                end
            end
            if (err_now && !err_prev) begin
                if (exp_q.size() == 0) check("unexpected_error", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("error_kind", bus.err_state ? 2 : 1, e.kind);
                    check("error_enable_cycles", en_cnt, e.cyc);
                end
            end
            err_prev = err_now;
            en_cnt   = bus.add_rst ? 0 : en_cnt + int'(bus.add_enable);
        end
    end

    task automatic run_pass(input int lat, input int odly, input int rdly, input logic [4:0] ops0, input bit bad);
        exp_t e;
        int   n, rst_seen, bad_cnt, exp_lat;
        e = model(lat, bad);
        exp_q.push_back(e);
        dp_lat        = lat;
        dp_bad        = bad;
        bus.ops_valid = odly > 0 ? ops0 : 5'b11111;
        bus.out_ready = rdly < 0;
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n       = 0;
        bad_cnt = 0;
        for (int i = 0; i < odly; i++) begin
            if (bus.add_enable || !bus.busy) bad_cnt++;
            @(posedge clk);
            #1 n++;
        end
        if (odly > 0) check("wait_ops_stall", bad_cnt, 0);
        bus.ops_valid = 5'b11111;
        rst_seen      = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            rst_seen += int'(bus.add_rst);
        end while (!(bus.out_valid || bus.err_timeout || bus.err_state) && n < 300);
        check("pass_terminates", int'(n < 300), 1);
        exp_lat = e.kind == 1 ? TIMEOUT + 2 + odly : lat + 3 + odly;
        check("pass_latency", n, exp_lat);
        if (bus.out_valid) begin
            check("clear_pulses", rst_seen, 1);
            if (rdly >= 0) begin
                bad_cnt = 0;
                @(posedge clk);
                #1 bad_cnt += int'(!bus.out_valid);
                for (int i = 0; i < rdly; i++) begin
                    bus.start = i == 0;
                    @(posedge clk);
                    #1 bus.start = 1'b0;
                    bad_cnt += int'(!bus.out_valid);
                end
                check("out_valid_held", bad_cnt, 0);
                bus.out_ready = 1'b1;
            end
            @(posedge clk);
            #1 bus.out_ready = 1'b0;
            @(negedge clk) check("idle_after_accept", int'(bus.busy), 0);
            @(negedge clk) check("no_queued_start", int'(bus.busy), 0);
        end else begin
            check("err_no_out_valid", int'(bus.out_valid), 0);
            bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            check("err_holds_rst", int'(bus.add_rst), 1);
            check("err_sticky", int'(bus.err_timeout || bus.err_state), 1);
            check("err_no_enable", int'(bus.add_enable), 0);
            bus.abort = 1'b1;
            @(posedge clk);
            #1 bus.abort = 1'b0;
            check("abort_clears_err", int'({bus.err_timeout, bus.err_state}), 0);
            check("abort_rst", int'(bus.add_rst), 1);
            @(posedge clk);
            #1 check("idle_after_abort", int'(bus.busy), 0);
        end
    endtask

    task automatic abort_run(input int k);
        int en, n;
        dp_lat        = 6;
        dp_bad        = 1'b0;
        bus.ops_valid = 5'b11111;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        en = 0;
        n  = 0;
        while (en < k && n < 50) begin
            @(negedge clk);
            en += int'(bus.add_enable);
            n++;
        end
        check("abort_reached_run", en, k);
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        check("abort_stops_enable", int'(bus.add_enable), 0);
        check("abort_asserts_rst", int'(bus.add_rst), 1);
        check("abort_no_result", int'(bus.out_valid), 0);
        @(posedge clk);
        #1 check("abort_to_idle", int'(bus.busy), 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.ops_valid = 5'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({bus.busy, bus.ops_hold, bus.add_rst, bus.add_enable,
                                     bus.out_valid, bus.err_timeout, bus.err_state}), 0);
        check("reset_run_cycles", int'(bus.run_cycles), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        check("abort_in_idle", int'(bus.busy), 0);

        run_pass(6, 0, -1, 5'b11111, 1'b0);
        check("nominal_run_cycles", int'(bus.run_cycles), 7);
        run_pass(6, 20, -1, 5'b01111, 1'b0);
        run_pass(1000, 0, -1, 5'b11111, 1'b0);
        run_pass(6, 0, 10, 5'b11111, 1'b0);
        abort_run(3);
        run_pass(6, 0, -1, 5'b11111, 1'b0);
        run_pass(15, 0, 0, 5'b11111, 1'b0);
        run_pass(16, 1, 0, 5'b10111, 1'b0);
`ifdef ADD_SEQ_CTRL_STATE_CHECK_EN
        run_pass(6, 0, -1, 5'b11111, 1'b1);
`endif
        for (int i = 0; i < 25; i++)
            run_pass($urandom_range(20, 1), $urandom_range(4, 0), int'($urandom_range(4, 0)) - 1,
                     ~(5'b00001 << $urandom_range(4, 0)), 1'b0);

        dp_lat        = 6;
        bus.ops_valid = 5'b11111;
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1 check("async_reset_mid_pass", int'({bus.busy, bus.add_enable, bus.add_rst, bus.out_valid}), 0);
        check("async_reset_run_cycles", int'(bus.run_cycles), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 check("idle_after_reset", int'(bus.busy), 0);
        run_pass(6, 0, -1, 5'b11111, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
